// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: fetches a message from word memory and streams SHA-256 padded 512-bit blocks; SHA_PAD_BYTESWAP_EN byte-reverses memory words
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;
  localparam int NB = (NUM_OF_WORDS + 18) / 16;
  localparam logic [63:0] LEN = 64'(NUM_OF_WORDS) * 64'd32;
  state_t state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [9:0] blk_q, blk_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [511:0] data_q, data_d;
  logic pend_mem_q, pend_mem_d;
  logic [31:0] pend_val_q, pend_val_d;
  logic [31:0] g, fill_word, mem_word;
  logic rd, last;
`ifdef SHA_PAD_BYTESWAP_EN
  assign mem_word = {mem_read_data[7:0], mem_read_data[15:8], mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign mem_word = mem_read_data;
`endif
  always_comb begin
    g = 32'(blk_q) * 32'd16 + 32'(k_q);
    last = blk_q == 10'(NB - 1);
    rd = state_q == FILL && !k_q[4] && g < 32'(NUM_OF_WORDS);
    fill_word = (g == 32'(NUM_OF_WORDS)) ? 32'h8000_0000 :
                (g == 32'(16*NB-2))     ? LEN[63:32] :
                (g == 32'(16*NB-1))     ? LEN[31:0] : '0;
    state_d = state_q;
    k_d = k_q;
    blk_d = blk_q;
    base_d = base_q;
    data_d = data_q;
    pend_mem_d = rd;
    pend_val_d = fill_word;
    case (state_q)
      IDLE: if (start) begin
        base_d = message_addr;
        k_d = '0;
        blk_d = '0;
        state_d = FILL;
      end
      FILL: begin
        // each slot lands one edge after its index is issued; shifting puts word 0 on top after 16 captures
        if (k_q != '0) data_d = {data_q[479:0], pend_mem_q ? mem_word : pend_val_q};
        k_d = k_q + 5'd1;
        if (k_q[4]) state_d = HOLD;
      end
      HOLD: if (blk_ready) begin
        state_d = last ? DONE : FILL;
        blk_d = last ? blk_q : blk_q + 10'd1;
        k_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      blk_q <= '0;
      base_q <= '0;
      data_q <= '0;
      pend_mem_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      blk_q <= blk_d;
      base_q <= base_d;
      data_q <= data_d;
      pend_mem_q <= pend_mem_d;
      pend_val_q <= pend_val_d;
    end
  end
  assign mem_rd = rd;
  assign mem_addr = rd ? base_q + ADDR_W'(g) : '0;
  assign blk_valid = state_q == HOLD;
  assign blk_last = (state_q == FILL || state_q == HOLD) && last;
  assign blk_data = data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed checks of three padder instances (20, 13 and 14 words)
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] start = '0, ready = '0;
  logic [15:0] maddr = '0;
  logic [2:0] mem_rd, valid, last, busy, done;
  logic [2:0][15:0] mem_addr;
  logic [2:0][511:0] bdata;
  logic [31:0] mem [0:65535];
  int n_chk = 0, n_fail = 0;
  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [31:0] rd;
    always @(posedge clk) if (mem_rd[i]) rd <= mem[mem_addr[i]];
    sha256_msg_padder #(.NUM_OF_WORDS(i == 0 ? 20 : (i == 1 ? 13 : 14)), .ADDR_W(16)) u_dut (
      .clk(clk), .reset(rst), .start(start[i]), .message_addr(maddr),
      .mem_rd(mem_rd[i]), .mem_addr(mem_addr[i]), .mem_read_data(rd),
      .blk_valid(valid[i]), .blk_ready(ready[i]), .blk_data(bdata[i]),
      .blk_last(last[i]), .busy(busy[i]), .done(done[i]));
  end
  function automatic logic [31:0] swapw(input logic [31:0] w);
`ifdef SHA_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction
  function automatic logic [31:0] expw(input int num, input int base, input int gi);
    int nb = (num + 18) / 16;
    if (gi < num) return swapw(mem[16'(base + gi)]);
    if (gi == num) return 32'h8000_0000;
    if (gi == 16*nb-1) return 32'(num * 32);
    return 32'h0;
  endfunction
  function automatic logic [511:0] exp_blk(input int num, input int base, input int b);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = expw(num, base, 16*b + k);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic wait_valid(input int i, output int n, output int rds);
    n = 0;
    rds = 0;
    while (n < 40) begin
      @(negedge clk);
      rds += int'(mem_rd[i]);
      @(posedge clk);
      n++;
      #1;
      if (valid[i]) break;
    end
  endtask
  task automatic kick(input int i, input logic [15:0] a);
    @(negedge clk);
    maddr = a;
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask
  task automatic accept(input int i);
    @(negedge clk);
    ready[i] = 1'b1;
    @(posedge clk);
    #1 ready[i] = 1'b0;
  endtask
  task automatic do_block(input string tag, input int i, input int num, input int base, input int b, input logic el);
    int n, rds, er;
    er = num - 16*b;
    er = er < 0 ? 0 : (er > 16 ? 16 : er);
    wait_valid(i, n, rds);
    chk({tag, "_latency"}, 512'(n), 512'd17);
    chk({tag, "_reads"}, 512'(rds), 512'(er));
    chk({tag, "_data"}, bdata[i], exp_blk(num, base, b));
    chk({tag, "_last"}, 512'(last[i]), 512'(el));
  endtask
  task automatic fin(input string tag, input int i);
    chk({tag, "_done"}, 512'({done[i], valid[i]}), 512'b10);
    @(posedge clk);
    #1 chk({tag, "_idle"}, 512'({done[i], busy[i]}), 512'b00);
  endtask
  initial begin
    logic [511:0] snap;
    int bad, n, rds;
    for (int j = 0; j < 65536; j++) mem[j] = {16'h5A5A, 16'(j)};
    for (int j = 0; j < 20; j++) mem[16'h100 + j] = 32'hA000_0000 + 32'(j);
    mem[16'h200] = 32'h1122_3344;
    for (int j = 1; j < 16; j++) mem[16'h200 + j] = 32'hB000_0000 + 32'(j);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 512'({valid, last, busy, done, mem_rd}), '0);
    chk("rst_addr", 512'(mem_addr), '0);
    for (int i = 0; i < 3; i++) chk("rst_data", bdata[i], '0);
    rst = 1'b0;
    kick(0, 16'h100);
    do_block("a_b0", 0, 20, 'h100, 0, 1'b0);
    chk("a_b0_w0", 512'(bdata[0][511:480]), 512'h A000_0000);
    accept(0);
    do_block("a_b1", 0, 20, 'h100, 1, 1'b1);
    chk("a_b1_w3", 512'(bdata[0][415:384]), 512'hA000_0013);
    chk("a_b1_w4", 512'(bdata[0][383:352]), 512'h8000_0000);
    chk("a_b1_len", bdata[0][63:0], 512'h280);
    accept(0);
    fin("a", 0);
    kick(1, 16'h200);
    do_block("b", 1, 13, 'h200, 0, 1'b1);
`ifdef SHA_PAD_BYTESWAP_EN
    chk("b_w0", 512'(bdata[1][511:480]), 512'h4433_2211);
`else
    chk("b_w0", 512'(bdata[1][511:480]), 512'h1122_3344);
`endif
    chk("b_w13", 512'(bdata[1][95:64]), 512'h8000_0000);
    chk("b_len", bdata[1][63:0], 512'h1A0);
    accept(1);
    fin("b", 1);
    kick(2, 16'h200);
    do_block("c_b0", 2, 14, 'h200, 0, 1'b0);
    chk("c_b0_tail", bdata[2][63:0], 512'h8000_0000_0000_0000);
    accept(2);
    do_block("c_b1", 2, 14, 'h200, 1, 1'b1);
    chk("c_b1_lit", bdata[2], 512'h1C0);
    accept(2);
    fin("c", 2);
    kick(0, 16'h100);
    do_block("bp_b0", 0, 20, 'h100, 0, 1'b0);
    snap = bdata[0];
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_rd[0] !== 1'b0 || bdata[0] !== snap || valid[0] !== 1'b1) bad++;
    end
    chk("bp_stable", 512'(bad), 512'd0);
    accept(0);
    do_block("bp_b1", 0, 20, 'h100, 1, 1'b1);
    accept(0);
    fin("bp", 0);
    kick(1, 16'h200);
    repeat (2) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    @(posedge clk);
    #1 chk("r_addr4", 512'({mem_rd[1], mem_addr[1]}), 512'h1_0204);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("r_ctrl", 512'({valid[1], last[1], busy[1], done[1], mem_rd[1]}), '0);
    chk("r_addr", 512'(mem_addr[1]), '0);
    chk("r_data", bdata[1], '0);
    rst = 1'b0;
    wait_valid(1, n, rds);
    chk("r_noreads", 512'({valid[1], 16'(rds)}), '0);
    kick(1, 16'hFFF8);
    do_block("w", 1, 13, 'hFFF8, 0, 1'b1);
    chk("w_w8", 512'(bdata[1][255:224]), 512'(swapw(32'h5A5A_0000)));
    accept(1);
    fin("w", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
